pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush, bubble insertion and an optional two-entry skid buffer. It generalises the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block that sits between any two stages. It supports stalls, where the stage holds its contents, and flushes, where it kills the in-flight instruction after a branch or jump. Control bits and datapath payload are kept as separate fields, so a bubble always presents all-zero control downstream.

---
 rtl/pipe_stage_buf.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: reusable pipeline-stage register with valid/ready handshake,
// synchronous flush, bubble insertion (control forced to zero when invalid)
// and a saturating back-pressure counter.
// Optional feature macro: PIPE_SKID_EN adds a second (skid) entry so that
// in_ready is registered and carries no combinational path from out_ready.
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;
    logic                m_valid;
    logic [CTRL_W-1:0]   m_ctrl;
    logic [DATA_W-1:0]   m_data;
    logic [1:0]          occ_r;
    logic                accept;
    logic                take;

`ifdef PIPE_SKID_EN
    logic                s_valid;
    logic [CTRL_W-1:0]   s_ctrl;
    logic [DATA_W-1:0]   s_data;

    // Ready is a pure function of the skid register, so it is registered.
    assign in_ready = ~s_valid;
`else
    // Single register: a slot frees up whenever the current entry leaves.
    assign in_ready = out_ready | ~m_valid;
`endif

    assign accept    = in_valid & in_ready;
    assign take      = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;
    assign occ       = occ_r;

    // Occupancy FSM moving entries through M (and S when present).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
            occ_r   <= 2'd0;
`ifdef PIPE_SKID_EN
            s_valid <= 1'b0;
            s_ctrl  <= '0;
            s_data  <= '0;
`endif
        end else if (flush) begin
            // Kill every held entry; payload registers keep their contents.
            state   <= EMPTY;
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            occ_r   <= 2'd0;
`ifdef PIPE_SKID_EN
            s_valid <= 1'b0;
            s_ctrl  <= '0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= in_ctrl;
                        m_data  <= in_data;
                        state   <= ONE;
                        occ_r   <= 2'd1;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                    end else if (accept) begin
`ifdef PIPE_SKID_EN
                        s_valid <= 1'b1;
                        s_ctrl  <= in_ctrl;
                        s_data  <= in_data;
                        state   <= FULL;
                        occ_r   <= 2'd2;
`else
                        // Unreachable: in ONE, accept implies take here.
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
`endif
                    end else if (take) begin
                        // Bubble: invalid entry always presents zero control.
                        m_valid <= 1'b0;
                        m_ctrl  <= '0;
                        state   <= EMPTY;
                        occ_r   <= 2'd0;
                    end
                end
`ifdef PIPE_SKID_EN
                FULL: begin
                    if (take) begin
                        m_ctrl  <= s_ctrl;
                        m_data  <= s_data;
                        s_valid <= 1'b0;
                        s_ctrl  <= '0;
                        state   <= ONE;
                        occ_r   <= 2'd1;
                    end
                end
`endif
                default: begin
                    state   <= EMPTY;
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    occ_r   <= 2'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles where a valid entry is held back; flush-immune.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scenario-driven bench comparing pipe_stage_buf against a
// queue-based model of the stage (FIFO of beats with capacity 1 or 2).
// Build with PIPE_SKID_EN defined to exercise the skid-buffer variant.
module tb_pipe_stage_buf;

    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int NW  = 4;
    localparam int SAT = (1 << NW) - 1;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          clrn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;
    logic [NW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] mdata;
    int            mcnt;

    logic [55:0]   act;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .clrn(clrn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occ(occ), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign act = {out_valid, out_ctrl, out_data, occ, in_ready, stall_cnt};

    // Ready as seen by the producer in the current cycle.
    function automatic logic m_ready();
`ifdef PIPE_SKID_EN
        return q.size() < 2;
`else
        return out_ready || (q.size() == 0);
`endif
    endfunction

    // Expected {out_valid, out_ctrl, out_data, occ, in_ready, stall_cnt}.
    function automatic logic [55:0] expv();
        logic          v;
        logic [CW-1:0] c;
        v = q.size() > 0;
        c = v ? q[0].c : '0;
        return {v, c, mdata, 2'(q.size()), m_ready(), 4'(mcnt)};
    endfunction

    // Advance model and clock by one edge using the currently driven inputs.
    task automatic tick();
        logic acc, tk;
        acc = in_valid && m_ready();
        tk  = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && (mcnt < SAT)) mcnt++;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (tk) void'(q.pop_front());
            if (acc) q.push_back({in_ctrl, in_data});
        end
        if (q.size() > 0) mdata = q[0].d;
        #1;
    endtask

    task automatic do_reset();
        clrn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        q.delete(); mdata = '0; mcnt = 0;
        #3;
        clrn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        // Load an entry, then reset asynchronously mid-cycle.
        in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
        tick();
        #2;
        clrn = 1'b0;
        q.delete(); mdata = '0; mcnt = 0;
        #1;
        checks++;
        if (act !== expv()) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", act, expv());
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_ctrl, occ, in_ready} !== {1'b0, 16'h0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold: got v=%b c=%h occ=%0d rdy=%b want 0 0 0 1",
                     out_valid, out_ctrl, occ, in_ready);
        end
        #3;
        clrn = 1'b1;
        in_data = 32'h1234; out_ready = 1'b1;
        #1;
        tick();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h1234} || act !== expv()) begin
            errors++;
            $display("FAIL reset_first_beat: got %h want %h (data 1234)", act, expv());
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i); in_ctrl = 16'($urandom);
            #1;
            tick();
            checks++;
            if (out_data !== 32'(i) || occ !== 2'd1 || act !== expv()) begin
                errors++;
                $display("FAIL stream_%0d: got %h want %h", i, act, expv());
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] seen[$];
        int maxocc = 0;
        int nxt = 1;
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 7);
            in_valid  = (nxt <= 8) && (cyc < 10);
            in_data   = 32'(nxt);
            in_ctrl   = 16'(nxt) | 16'h8000;
            #1;
            checks++;
            if (act !== expv()) begin
                errors++;
                $display("FAIL backpressure_c%0d: got %h want %h", cyc, act, expv());
            end
            if (out_valid && out_ready) seen.push_back(out_data);
            if (in_valid && in_ready) nxt++;
            tick();
            if (int'(occ) > maxocc) maxocc = int'(occ);
            if (cyc == 6) begin
                checks++;
                if (stall_cnt !== 4'd3) begin
                    errors++;
                    $display("FAIL backpressure_stallcnt: got %0d want 3", stall_cnt);
                end
            end
        end
        checks++;
        if (maxocc != CAP) begin
            errors++;
            $display("FAIL backpressure_maxocc: got %0d want %0d", maxocc, CAP);
        end
        checks++;
        if (seen.size() != nxt - 1) begin
            errors++;
            $display("FAIL backpressure_count: got %0d want %0d", seen.size(), nxt - 1);
        end else begin
            for (int k = 0; k < seen.size(); k++) begin
                if (seen[k] !== 32'(k + 1)) begin
                    errors++;
                    $display("FAIL backpressure_order[%0d]: got %0d want %0d", k, seen[k], k + 1);
                    break;
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'd5; in_ctrl = 16'h0505; tick();
        in_data = 32'd6; in_ctrl = 16'h0606; tick();
        flush = 1'b1; in_data = 32'd7; in_ctrl = 16'h0707; tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, out_ctrl, occ} !== {1'b0, 16'h0, 2'd0} || act !== expv()) begin
            errors++;
            $display("FAIL flush_kill: got %h want %h", act, expv());
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ((out_valid && out_data == 32'd7) || act !== expv()) begin
                errors++;
                $display("FAIL flush_after_%0d: got %h want %h", i, act, expv());
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5; in_ctrl = 16'h1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (act !== expv()) begin
                errors++;
                $display("FAIL saturation_%0d: got %h want %h", i, act, expv());
            end
        end
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL saturation_final: got %0d want 15", stall_cnt);
        end
        // Flush does not touch the stall counter.
        flush = 1'b1; tick(); flush = 1'b0; #1;
        checks++;
        if (stall_cnt !== 4'd15 || act !== expv()) begin
            errors++;
            $display("FAIL saturation_flush: got %h want %h", act, expv());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = $urandom;
            in_ctrl   = 16'($urandom);
            #1;
            checks++;
            if (act !== expv()) begin
                errors++;
                $display("FAIL random_%0d: got %h want %h", i, act, expv());
            end
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0; mdata = '0; mcnt = 0;
        @(posedge clk); #1;
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
